// File: rtl/hs4_sync_sink.sv
// hs4_sync_sink
// Clocked receiving end of a 4-phase return-to-zero bundled-data handshake.
// The asynchronous request is synchronized, each token's bundled data is
// captured into a small circular FIFO, the acknowledge is returned from a
// register, and the FIFO head is presented as a valid/ready stream.
//
// Ports:
//   clk_i      single clock
//   rst_i      synchronous active-high reset
//   req_i      asynchronous request from the upstream controller
//   data_i     bundled data, stable from req_i rise until ack_o rises
//   ack_o      registered acknowledge to the upstream controller
//   m_valid_o  stream data valid (FIFO not empty)
//   m_data_o   stream data (FIFO head, 0 when empty)
//   m_ready_i  stream consumer ready
//   level_o    current FIFO occupancy
module hs4_sync_sink #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic                       ack_o,
    output logic                       m_valid_o,
    output logic [DATA_W-1:0]          m_data_o,
    input  logic                       m_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ARM_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [SYNC_STAGES-1:0] req_sync_p0;
    logic               req_s;
    logic [ARM_W-1:0]   arm_cnt;
    logic               arm_done;
    logic               ack_q;
    logic               push;
    logic               pop;
    logic               full;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic [DATA_W-1:0]  mem [DEPTH];

    // ---- stage: request synchronizer ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_sync_p0 <= '0;
        end else begin
            req_sync_p0 <= {req_sync_p0[SYNC_STAGES-2:0], req_i};
        end
    end

    assign req_s = req_sync_p0[SYNC_STAGES-1];

    // The synchronizer restarts from zero on reset, so its output reads low
    // for SYNC_STAGES cycles even if req_i is held high. ARM therefore waits
    // until the chain has refilled from the live input before trusting a
    // low req_s; otherwise a request held across reset would be captured.
    always_ff @(posedge clk_i) begin
        if (rst_i || state != ARM) begin
            arm_cnt <= '0;
        end else if (!arm_done) begin
            arm_cnt <= arm_cnt + 1'b1;
        end
    end

    assign arm_done = (arm_cnt == ARM_W'(SYNC_STAGES));

    // ---- stage: handshake FSM ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ARM;
            ack_q <= 1'b0;
        end else begin
            state <= state_next;
            ack_q <= (state_next == ACK);
        end
    end

    assign full = (level == LVL_W'(DEPTH));

    // Acceptance uses the registered level, so a pop frees a slot for the
    // following cycle, never the same one.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            ARM: begin
                if (arm_done && !req_s) state_next = IDLE;
            end
            IDLE: begin
                if (req_s && !full) begin
                    push       = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!req_s) state_next = IDLE;
            end
            default: state_next = ARM;
        endcase
    end

    assign ack_o = ack_q;

    // ---- stage: FIFO ----
    assign m_valid_o = (level != '0);
    assign pop       = m_valid_o && m_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage is data only; validity comes from level, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= data_i;
    end

    assign m_data_o = m_valid_o ? mem[rd_ptr] : '0;
    assign level_o  = level;

endmodule

// File: tb/tb_hs4_sync_sink.sv
module tb_hs4_sync_sink;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk_i;
    logic              rst_i;
    logic              req_i;
    logic [DATA_W-1:0] data_i;
    logic              ack_o;
    logic              m_valid_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_ready_i;
    logic [2:0]        level_o;

    int checks;
    int errors;

    hs4_sync_sink #(
        .DATA_W(DATA_W),
        .SYNC_STAGES(2),
        .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_i(req_i),
        .data_i(data_i),
        .ack_o(ack_o),
        .m_valid_o(m_valid_o),
        .m_data_o(m_data_o),
        .m_ready_i(m_ready_i),
        .level_o(level_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Full 4-phase transaction with bounded waits on ack.
    task automatic send(input logic [31:0] d);
        int n;
        req_i  = 1'b1;
        data_i = d;
        n = 0;
        while (ack_o !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        check("send_ack_rise", 32'(ack_o), 32'd1);
        req_i = 1'b0;
        n = 0;
        while (ack_o !== 1'b0 && n < 50) begin
            cyc();
            n++;
        end
        check("send_ack_fall", 32'(ack_o), 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_i     = 1'b1;
        req_i     = 1'b0;
        data_i    = '0;
        m_ready_i = 1'b0;

        // Reset state
        cycles(2);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_valid", 32'(m_valid_o), 32'd0);
        check("rst_data", m_data_o, 32'd0);
        check("rst_level", 32'(level_o), 32'd0);
        rst_i = 1'b0;
        cycles(5);

        // Single token with latency checks
        m_ready_i = 1'b1;
        req_i  = 1'b1;
        data_i = 32'hA5A5_0001;
        cycles(2);
        check("t1_ack_early", 32'(ack_o), 32'd0);
        check("t1_valid_early", 32'(m_valid_o), 32'd0);
        cyc();
        check("t1_ack_rise", 32'(ack_o), 32'd1);
        check("t1_valid", 32'(m_valid_o), 32'd1);
        check("t1_data", m_data_o, 32'hA5A5_0001);
        check("t1_level1", 32'(level_o), 32'd1);
        cyc();
        check("t1_valid_gone", 32'(m_valid_o), 32'd0);
        check("t1_level0", 32'(level_o), 32'd0);
        req_i = 1'b0;
        cycles(2);
        check("t1_ack_hold", 32'(ack_o), 32'd1);
        cyc();
        check("t1_ack_fall", 32'(ack_o), 32'd0);
        m_ready_i = 1'b0;
        cycles(2);

        // Burst of three, drained in order
        send(32'h11);
        send(32'h22);
        send(32'h33);
        check("t2_level", 32'(level_o), 32'd3);
        m_ready_i = 1'b1;
        check("t2_d0", m_data_o, 32'h11);
        cyc();
        check("t2_d1", m_data_o, 32'h22);
        cyc();
        check("t2_d2", m_data_o, 32'h33);
        cyc();
        check("t2_empty", 32'(m_valid_o), 32'd0);
        m_ready_i = 1'b0;

        // Backpressure: fifth token stalls until one pop
        for (int i = 1; i <= 4; i++) send(32'(i));
        check("t3_full", 32'(level_o), 32'd4);
        req_i  = 1'b1;
        data_i = 32'd5;
        cycles(10);
        check("t3_stall_ack", 32'(ack_o), 32'd0);
        check("t3_stall_level", 32'(level_o), 32'd4);
        check("t3_head", m_data_o, 32'd1);
        m_ready_i = 1'b1;
        cyc();
        m_ready_i = 1'b0;
        check("t3_pop_ack", 32'(ack_o), 32'd0);
        check("t3_pop_level", 32'(level_o), 32'd3);
        cyc();
        check("t3_late_ack", 32'(ack_o), 32'd1);
        check("t3_refill", 32'(level_o), 32'd4);
        req_i = 1'b0;
        cycles(3);
        check("t3_ack_fall", 32'(ack_o), 32'd0);
        m_ready_i = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check("t3_order", m_data_o, 32'(i));
            cyc();
        end
        check("t3_empty", 32'(m_valid_o), 32'd0);
        m_ready_i = 1'b0;

        // Request held high across a reset pulse
        req_i  = 1'b1;
        data_i = 32'h99;
        rst_i  = 1'b1;
        cyc();
        rst_i = 1'b0;
        cycles(10);
        check("t4_stale_ack", 32'(ack_o), 32'd0);
        check("t4_stale_level", 32'(level_o), 32'd0);
        req_i = 1'b0;
        cycles(5);
        send(32'h77);
        check("t4_level", 32'(level_o), 32'd1);
        check("t4_data", m_data_o, 32'h77);
        m_ready_i = 1'b1;
        cyc();
        m_ready_i = 1'b0;
        check("t4_once", 32'(level_o), 32'd0);

        // Push and pop on the same edge, wrapping pointers twice
        send(32'h100);
        for (int i = 1; i <= 2 * DEPTH; i++) begin
            req_i  = 1'b1;
            data_i = 32'h100 + 32'(i);
            cycles(2);
            m_ready_i = 1'b1;
            check("t5_head", m_data_o, 32'h100 + 32'(i - 1));
            cyc();
            m_ready_i = 1'b0;
            check("t5_ack", 32'(ack_o), 32'd1);
            check("t5_level", 32'(level_o), 32'd1);
            req_i = 1'b0;
            cycles(3);
            check("t5_ack_fall", 32'(ack_o), 32'd0);
        end
        check("t5_last", m_data_o, 32'h108);
        m_ready_i = 1'b1;
        cyc();
        m_ready_i = 1'b0;
        check("t5_empty", 32'(level_o), 32'd0);

        // Data changes after ack rises must not reach storage
        req_i  = 1'b1;
        data_i = 32'hCAFE_0006;
        cycles(3);
        check("t6_ack", 32'(ack_o), 32'd1);
        cyc();
        data_i = 32'hDEAD;
        req_i  = 1'b0;
        cycles(3);
        check("t6_ack_fall", 32'(ack_o), 32'd0);
        check("t6_data", m_data_o, 32'hCAFE_0006);

        // Reset in the middle of a handshake with a non-empty FIFO
        req_i  = 1'b1;
        data_i = 32'h55;
        cycles(3);
        check("t7_ack_pre", 32'(ack_o), 32'd1);
        check("t7_level_pre", 32'(level_o), 32'd2);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        check("t7_ack", 32'(ack_o), 32'd0);
        check("t7_level", 32'(level_o), 32'd0);
        check("t7_valid", 32'(m_valid_o), 32'd0);
        check("t7_data", m_data_o, 32'd0);
        cycles(6);
        check("t7_no_recapture", 32'(ack_o), 32'd0);
        req_i = 1'b0;
        cycles(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
